reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump_if.sv | 30 +++
 rtl/reg_dump.sv | 110 +++++++++++
 tb/tb_reg_dump.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_if.sv
// Register-file read port plus the valid/ready byte stream that reg_dump drives.
interface reg_dump_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rs_addr;
    logic [DATA_W-1:0] rs_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output rs_addr,
        output out_valid,
        output out_data,
        output out_last,
        input  rs_data,
        input  out_ready
    );

    modport slave (
        input  rs_addr,
        input  out_valid,
        input  out_data,
        input  out_last,
        output rs_data,
        output out_ready
    );
endinterface

// File: rtl/reg_dump.sv
// Streams every register-file entry out as bytes, then appends a modular-sum
// checksum byte flagged with out_last, and pulses done once it is accepted.
module reg_dump #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    reg_dump_if.master    bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            r_state, w_nextState;
    logic [ADDR_W-1:0] r_idx, w_nextIdx;
    logic [DATA_W-1:0] r_sum, w_nextSum;
    logic [DATA_W-1:0] r_outData, w_nextOutData;
    logic              r_outValid, w_nextOutValid;
    logic              r_outLast, w_nextOutLast;
    logic              w_handshake;

    assign w_handshake = r_outValid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_sum      <= '0;
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_idx      <= w_nextIdx;
            r_sum      <= w_nextSum;
            r_outData  <= w_nextOutData;
            r_outValid <= w_nextOutValid;
            r_outLast  <= w_nextOutLast;
        end
    end

    // Stream outputs only move on a handshake, so a stalled byte stays put.
    always_comb begin
        w_nextState    = r_state;
        w_nextIdx      = r_idx;
        w_nextSum      = r_sum;
        w_nextOutData  = r_outData;
        w_nextOutValid = r_outValid;
        w_nextOutLast  = r_outLast;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_READ;
                    w_nextIdx   = '0;
                    w_nextSum   = '0;
                end
            end
            S_READ: begin
                w_nextOutData  = bus.rs_data;
                w_nextSum      = r_sum + bus.rs_data;
                w_nextOutValid = 1'b1;
                w_nextState    = S_SEND;
            end
            S_SEND: begin
                if (w_handshake) begin
                    if (r_idx == LAST_IDX) begin
                        w_nextOutData = r_sum;
                        w_nextOutLast = 1'b1;
                        w_nextState   = S_CSUM;
                    end else begin
                        w_nextIdx      = r_idx + ADDR_W'(1);
                        w_nextOutValid = 1'b0;
                        w_nextState    = S_READ;
                    end
                end
            end
            S_CSUM: begin
                if (w_handshake) begin
                    w_nextOutValid = 1'b0;
                    w_nextOutLast  = 1'b0;
                    w_nextState    = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign bus.rs_addr   = (r_state == S_READ || r_state == S_SEND) ? r_idx : '0;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_last  = r_outLast;
    assign busy          = (r_state == S_READ) || (r_state == S_SEND) || (r_state == S_CSUM);
    assign done          = (r_state == S_DONE);
endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: table of dumps plus hand-written sequences
// for stalls, ignored starts, mid-dump reset and back-to-back dumps.
module tb_reg_dump;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 8;

    typedef struct {
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        int         stall;
        logic [7:0] csum;
    } vec_t;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;

    reg_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    logic [7:0] regs [NUM_REGS];
    assign bus.rs_data = regs[bus.rs_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] expQ [$];
    logic [8:0] popped;
    int         doneCount = 0;
    int         lastDoneCycle = -1;
    int         prevDoneCycle = -1;
    int         firstValidCycle = -1;
    logic       lastStall = 1'b0;
    logic [7:0] prevData = '0;
    logic       prevLast = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard side: bytes are popped and compared when a handshake is seen.
    always @(negedge clk) begin
        if (!reset) begin
            if (lastStall) begin
                checkOutput("holdValid", 32'(bus.out_valid), 32'd1);
                checkOutput("holdData", 32'(bus.out_data), 32'(prevData));
                checkOutput("holdLast", 32'(bus.out_last), 32'(prevLast));
            end
            if (bus.out_valid && firstValidCycle < 0) firstValidCycle = cycle;
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedByte: got data %0d last %0d expected no byte",
                             bus.out_data, bus.out_last);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("streamData", 32'(bus.out_data), 32'(popped[7:0]));
                    checkOutput("streamLast", 32'(bus.out_last), 32'(popped[8]));
                end
            end
            if (done) begin
                doneCount++;
                prevDoneCycle = lastDoneCycle;
                lastDoneCycle = cycle;
            end
            lastStall = bus.out_valid && !bus.out_ready;
            prevData  = bus.out_data;
            prevLast  = bus.out_last;
        end else begin
            lastStall = 1'b0;
        end
    end

    task automatic pushDump(input logic [7:0] a, b, c, d, input logic [7:0] csum);
        expQ.push_back({1'b0, a});
        expQ.push_back({1'b0, b});
        expQ.push_back({1'b0, c});
        expQ.push_back({1'b0, d});
        expQ.push_back({1'b1, csum});
    endtask

    task automatic waitDoneCount(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            #1;
            if (doneCount >= target) ok = 1'b1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int startEdge;
        int base;
        bit ok;
        regs[0] = v.r0; regs[1] = v.r1; regs[2] = v.r2; regs[3] = v.r3;
        bus.out_ready = (v.stall == 0);
        pushDump(v.r0, v.r1, v.r2, v.r3, v.csum);
        base = doneCount;
        firstValidCycle = -1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        startEdge = cycle;
        if (v.stall > 0) begin
            ok = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                if (bus.out_valid) ok = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            checkOutput("firstValidSeen", 32'(ok), 32'd1);
            checkOutput("stallFirstByte", 32'(bus.out_data), 32'(v.r0));
            repeat (v.stall) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
        end
        waitDoneCount(base + 1, 60, ok);
        checkOutput("doneSeen", 32'(ok), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("donePulses", 32'(doneCount - base), 32'd1);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        if (v.stall == 0) begin
            // done/valid seen after edge k are captured by edge k+1
            checkOutput("firstValidLatency", 32'(firstValidCycle + 1 - startEdge), 32'd2);
            checkOutput("dumpCycles", 32'(lastDoneCycle + 1 - startEdge), 32'(2 * NUM_REGS + 2));
        end
        expQ.delete();
    endtask

    vec_t vecs [6];

    initial begin
        int base;
        bit ok;
        vecs[0] = '{r0: 8'd5,   r1: 8'd10,  r2: 8'd15,  r3: 8'd20,  stall: 0, csum: 8'd50};
        vecs[1] = '{r0: 8'd5,   r1: 8'd10,  r2: 8'd15,  r3: 8'd20,  stall: 3, csum: 8'd50};
        vecs[2] = '{r0: 8'd200, r1: 8'd100, r2: 8'd0,   r3: 8'd1,   stall: 0, csum: 8'd45};
        vecs[3] = '{r0: 8'd255, r1: 8'd255, r2: 8'd255, r3: 8'd255, stall: 0, csum: 8'd252};
        vecs[4] = '{r0: 8'd0,   r1: 8'd0,   r2: 8'd0,   r3: 8'd0,   stall: 0, csum: 8'd0};
        vecs[5] = '{r0: 8'd128, r1: 8'd128, r2: 8'd7,   r3: 8'd9,   stall: 2, csum: 8'd16};

        reset = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetValid", 32'(bus.out_valid), 32'd0);
        checkOutput("resetLast", 32'(bus.out_last), 32'd0);
        checkOutput("resetData", 32'(bus.out_data), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetAddr", 32'(bus.rs_addr), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // start pulses while busy and during DONE must not spawn another dump
        regs[0] = 8'd5; regs[1] = 8'd10; regs[2] = 8'd15; regs[3] = 8'd20;
        pushDump(8'd5, 8'd10, 8'd15, 8'd20, 8'd50);
        base = doneCount;
        bus.out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) checkOutput("busyMidDump", 32'(busy), 32'd1);
            if (k == 9) begin
                checkOutput("doneInDone", 32'(done), 32'd1);
                checkOutput("busyInDone", 32'(busy), 32'd0);
            end
            start = (k == 3 || k == 6 || k == 9);
        end
        start = 1'b0;
        checkOutput("ignoredStartDones", 32'(doneCount - base), 32'd1);
        checkOutput("ignoredStartQueue", 32'(expQ.size()), 32'd0);
        expQ.delete();

        // reset right after the second byte is accepted abandons the dump
        pushDump(8'd5, 8'd10, 8'd15, 8'd20, 8'd50);
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        base = doneCount;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (expQ.size() == 0) ok = 1'b1;
        end
        checkOutput("twoBytesSeen", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midResetValid", 32'(bus.out_valid), 32'd0);
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        checkOutput("midResetLast", 32'(bus.out_last), 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midResetNoDone", 32'(doneCount - base), 32'd0);
        expQ.delete();
        applyStimulus(vecs[0]);

        // start held high: two dumps separated by DONE and IDLE
        pushDump(8'd5, 8'd10, 8'd15, 8'd20, 8'd50);
        pushDump(8'd5, 8'd10, 8'd15, 8'd20, 8'd50);
        base = doneCount;
        start = 1'b1;
        waitDoneCount(base + 2, 80, ok);
        start = 1'b0;
        checkOutput("b2bDoneSeen", 32'(ok), 32'd1);
        checkOutput("b2bGap", 32'(lastDoneCycle - prevDoneCycle), 32'(2 * NUM_REGS + 3));
        repeat (6) @(posedge clk);
        #1;
        checkOutput("b2bDones", 32'(doneCount - base), 32'd2);
        checkOutput("b2bQueue", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end
endmodule
